bram_burst_reader: RTL

Burst read front-end for the BRAM wrapper FSM. It accepts a (start address, length) command and issues single-word reads to the wrapper's `en`/`addr` port. Returned `dout`/`valid` words go into a small FIFO and leave on a ready/valid stream with a last-beat marker. Credit tracking guarantees a returned word never finds the FIFO full, so the wrapper needs no backpressure.

---
 rtl/bram_burst_reader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bram_burst_reader.sv
// Burst read front-end for the BRAM wrapper: turns (addr, len) commands into single-word
// reads, buffers returned words in a credit-protected FIFO and streams them out with a last marker.
module bram_burst_reader #(
  parameter int READ_LATENCY    = 3,
  parameter int ADDR_WIDTH      = 15,
  parameter int DATA_WIDTH      = 31,
  parameter int LEN_WIDTH       = 8,
  parameter int FIFO_DEPTH      = 8,
  parameter int MAX_OUTSTANDING = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  input  logic                  mem_valid,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FL_W   = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam int BEAT_W = LEN_WIDTH + 1;

  typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [FL_W-1:0]       flush_cnt;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [LEN_WIDTH-1:0]  remaining;
  logic [BEAT_W-1:0]     beats_total;
  logic [BEAT_W-1:0]     beats_out;
  logic [OUT_W-1:0]      outstanding;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic                  err_q;

  logic credit_ok, issue, push, pop, stray, cmd_fire;

  // Handshakes: a transfer happens in a cycle where valid and ready are both high;
  // a valid source holds its payload stable until that cycle (applies to cmd_* and m_*).
  assign cmd_fire = cmd_valid && cmd_ready;

  // Credits use registered counts only, so a pop in this cycle frees nothing until the next.
  assign credit_ok = (int'(outstanding) < MAX_OUTSTANDING) &&
                     ((int'(outstanding) + int'(fifo_count)) < FIFO_DEPTH);

  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    cmd_ready = 1'b0;
    case (state_q)
      S_FLUSH: if (flush_cnt == FL_W'(READ_LATENCY)) state_d = S_IDLE;
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (remaining == '0) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (outstanding == '0 && fifo_count == '0 && beats_out == beats_total)
          state_d = S_IDLE;
      end
      default: state_d = S_FLUSH;
    endcase
  end

  // Read strobe is decoded from registered state only; mem_addr holds the last issued address.
  assign mem_en   = issue;
  assign mem_addr = issue ? cur_addr : last_addr;
  assign mem_we   = 1'b0;
  assign mem_din  = '0;

  assign push    = mem_valid && (state_q != S_FLUSH) && (outstanding != '0);
  assign stray   = mem_valid && (state_q != S_FLUSH) && (outstanding == '0);
  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = fifo_mem[rd_ptr];
  assign m_last  = m_valid && (beats_out == (beats_total - BEAT_W'(1)));
  assign busy    = (state_q != S_IDLE);
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FLUSH;
      flush_cnt   <= '0;
      cur_addr    <= '0;
      last_addr   <= '0;
      remaining   <= '0;
      beats_total <= '0;
      beats_out   <= '0;
      outstanding <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_count  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q   <= state_d;
      flush_cnt <= (state_q == S_FLUSH) ? flush_cnt + FL_W'(1) : '0;

      if (issue) begin
        cur_addr  <= cur_addr + ADDR_WIDTH'(1);
        last_addr <= cur_addr;
        if (remaining != '0) remaining <= remaining - LEN_WIDTH'(1);
      end

      case ({issue, push})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase

      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        beats_out <= beats_out + BEAT_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase

      if (cmd_fire) begin
        cur_addr    <= cmd_addr;
        remaining   <= cmd_len;
        beats_total <= BEAT_W'(cmd_len) + BEAT_W'(1);
        beats_out   <= '0;
      end

      if (stray) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= mem_dout;
  end

endmodule
